// File: rtl/hdu_ctrl_if.sv
// Hazard-control bundle between the pipeline and hdu_ctrl.
// master = pipeline side, slave = hazard unit.
interface hdu_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              i_idex_rdwren;
  logic              i_idex_mem_rden;
  logic [REG_AW-1:0] i_idex_rd;
  logic [REG_AW-1:0] i_ifid_rs1;
  logic [REG_AW-1:0] i_ifid_rs2;
  logic              i_ifid_rs1_en;
  logic              i_ifid_rs2_en;
  logic              i_br_flush;
  logic              i_sram_stall;
  logic              i_ex_busy;
  logic              o_pc_wren;
  logic              o_ifid_wren;
  logic              o_idex_wren;
  logic              o_exmem_wren;
  logic              o_memwb_wren;
  logic              o_ifid_clear;
  logic              o_idex_clear;
  logic              o_exmem_clear;
  logic              o_lu_active;
  logic [CNT_W-1:0]  o_sram_stall_cnt;
  logic [CNT_W-1:0]  o_lu_bubble_cnt;
  logic [CNT_W-1:0]  o_flush_cnt;
  logic [CNT_W-1:0]  o_busy_cnt;

  modport master (
    output i_idex_rdwren, i_idex_mem_rden,
    output i_idex_rd, i_ifid_rs1, i_ifid_rs2,
    output i_ifid_rs1_en, i_ifid_rs2_en,
    output i_br_flush, i_sram_stall, i_ex_busy,
    input  o_pc_wren, o_ifid_wren, o_idex_wren,
    input  o_exmem_wren, o_memwb_wren,
    input  o_ifid_clear, o_idex_clear,
    input  o_exmem_clear, o_lu_active,
    input  o_sram_stall_cnt, o_lu_bubble_cnt,
    input  o_flush_cnt, o_busy_cnt
  );

  modport slave (
    input  i_idex_rdwren, i_idex_mem_rden,
    input  i_idex_rd, i_ifid_rs1, i_ifid_rs2,
    input  i_ifid_rs1_en, i_ifid_rs2_en,
    input  i_br_flush, i_sram_stall, i_ex_busy,
    output o_pc_wren, o_ifid_wren, o_idex_wren,
    output o_exmem_wren, o_memwb_wren,
    output o_ifid_clear, o_idex_clear,
    output o_exmem_clear, o_lu_active,
    output o_sram_stall_cnt, o_lu_bubble_cnt,
    output o_flush_cnt, o_busy_cnt
  );
endinterface

// File: rtl/hdu_ctrl.sv
// Multi-bubble hazard-control unit with latched SRAM-stall flush.
// HDU_PERF_CNT_EN builds saturating hazard perf counters.
module hdu_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input logic       i_clk,
  input logic       i_rst_n,
  hdu_ctrl_if.slave hdu
);

  typedef enum logic {
    IDLE,
    LU_STALL
  } state_e;

  localparam logic [2:0] BUB_INIT =
    3'(LOAD_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] bub_q, bub_d;
  logic       pend_q, pend_d;

  logic lu_hit, flush;
  logic r_sram, r_flush, r_busy, r_lu;
  logic rs1_hit, rs2_hit;

  logic pc_we, ifid_we, idex_we;
  logic exmem_we, memwb_we;
  logic ifid_clr, idex_clr, exmem_clr;

  always_comb begin
    rs1_hit = hdu.i_ifid_rs1_en &
              (hdu.i_idex_rd == hdu.i_ifid_rs1);
    rs2_hit = hdu.i_ifid_rs2_en &
              (hdu.i_idex_rd == hdu.i_ifid_rs2);
    lu_hit  = hdu.i_idex_mem_rden &
              hdu.i_idex_rdwren &
              (hdu.i_idex_rd != '0) &
              (rs1_hit | rs2_hit);
    flush   = hdu.i_br_flush | pend_q;
    r_sram  = hdu.i_sram_stall;
    r_flush = !r_sram & flush;
    r_busy  = !r_sram & !flush & hdu.i_ex_busy;
    r_lu    = !r_sram & !flush & !hdu.i_ex_busy &
              ((state_q == LU_STALL) | lu_hit);
  end

  always_comb begin
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    idex_we   = 1'b1;
    exmem_we  = 1'b1;
    memwb_we  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    state_d   = state_q;
    bub_d     = bub_q;
    pend_d    = pend_q;
    unique case (1'b1)
      r_sram: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        memwb_we = 1'b0;
        pend_d   = pend_q | hdu.i_br_flush;
      end
      r_flush: begin
        ifid_clr  = 1'b1;
        idex_clr  = 1'b1;
        exmem_clr = 1'b1;
        state_d   = IDLE;
        bub_d     = '0;
        pend_d    = 1'b0;
      end
      r_busy: begin
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        idex_we   = 1'b0;
        exmem_clr = 1'b1;
      end
      r_lu: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_clr = 1'b1;
        if (state_q == IDLE) begin
          if (LOAD_LAT > 1) begin
            state_d = LU_STALL;
            bub_d   = BUB_INIT;
          end
        end else begin
          bub_d = bub_q - 3'd1;
          if (bub_q == 3'd1) state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      bub_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      pend_q  <= pend_d;
    end
  end

  // Reset forces the pipeline quiet and clear independent of the clock.
  always_comb begin
    hdu.o_pc_wren     = pc_we & i_rst_n;
    hdu.o_ifid_wren   = ifid_we & i_rst_n;
    hdu.o_idex_wren   = idex_we & i_rst_n;
    hdu.o_exmem_wren  = exmem_we & i_rst_n;
    hdu.o_memwb_wren  = memwb_we & i_rst_n;
    hdu.o_ifid_clear  = ifid_clr | !i_rst_n;
    hdu.o_idex_clear  = idex_clr | !i_rst_n;
    hdu.o_exmem_clear = exmem_clr | !i_rst_n;
    hdu.o_lu_active   = (state_q == LU_STALL);
  end

`ifdef HDU_PERF_CNT_EN
  logic [CNT_W-1:0] sram_cnt_q, lu_cnt_q;
  logic [CNT_W-1:0] fl_cnt_q, busy_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sram_cnt_q <= '0;
      lu_cnt_q   <= '0;
      fl_cnt_q   <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (r_sram)  sram_cnt_q <= sat_inc(sram_cnt_q);
      if (r_lu)    lu_cnt_q   <= sat_inc(lu_cnt_q);
      if (r_flush) fl_cnt_q   <= sat_inc(fl_cnt_q);
      if (r_busy)  busy_cnt_q <= sat_inc(busy_cnt_q);
    end
  end

  always_comb begin
    hdu.o_sram_stall_cnt = sram_cnt_q;
    hdu.o_lu_bubble_cnt  = lu_cnt_q;
    hdu.o_flush_cnt      = fl_cnt_q;
    hdu.o_busy_cnt       = busy_cnt_q;
  end
`else
  always_comb begin
    hdu.o_sram_stall_cnt = '0;
    hdu.o_lu_bubble_cnt  = '0;
    hdu.o_flush_cnt      = '0;
    hdu.o_busy_cnt       = '0;
  end
`endif

endmodule

// File: tb/tb_hdu_ctrl.sv
// Directed bench for hdu_ctrl: LOAD_LAT=1 and LOAD_LAT=3/CNT_W=4
// instances driven in lockstep from one vector table.
module tb_hdu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hdu_ctrl_if #(.REG_AW(5), .CNT_W(32)) b1();
  hdu_ctrl_if #(.REG_AW(5), .CNT_W(4))  b3();

  hdu_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .hdu(b1)
  );
  hdu_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .hdu(b3)
  );

  // {pc,ifid,idex,exmem,memwb wren, ifid,idex,exmem clr, lu}
  localparam logic [8:0] NORM  = 9'b11111_000_0;
  localparam logic [8:0] BUB0  = 9'b00111_010_0;
  localparam logic [8:0] BUB1  = 9'b00111_010_1;
  localparam logic [8:0] STAL  = 9'b00000_000_0;
  localparam logic [8:0] STAL1 = 9'b00000_000_1;
  localparam logic [8:0] FLSH  = 9'b11111_111_0;
  localparam logic [8:0] FLSH1 = 9'b11111_111_1;
  localparam logic [8:0] BUSY  = 9'b00011_001_0;
  localparam logic [8:0] BUSY1 = 9'b00011_001_1;
  localparam logic [8:0] RST   = 9'b00000_111_0;

  logic [8:0] o1, o3;
  assign o1 = {b1.o_pc_wren, b1.o_ifid_wren, b1.o_idex_wren,
               b1.o_exmem_wren, b1.o_memwb_wren,
               b1.o_ifid_clear, b1.o_idex_clear,
               b1.o_exmem_clear, b1.o_lu_active};
  assign o3 = {b3.o_pc_wren, b3.o_ifid_wren, b3.o_idex_wren,
               b3.o_exmem_wren, b3.o_memwb_wren,
               b3.o_ifid_clear, b3.o_idex_clear,
               b3.o_exmem_clear, b3.o_lu_active};

  typedef struct {
    logic       ld;
    logic [4:0] rd, rs1, rs2;
    logic       e1n, e2n, br, sr, bz;
    logic [8:0] x1, x3;
  } vec_t;

  vec_t tv[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(
    input logic ld, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic e1n, input logic e2n,
    input logic br, input logic sr, input logic bz,
    input logic [8:0] x1, input logic [8:0] x3
  );
    vec_t v;
    v.ld = ld; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.e1n = e1n; v.e2n = e2n;
    v.br = br; v.sr = sr; v.bz = bz;
    v.x1 = x1; v.x3 = x3;
    return v;
  endfunction

  function automatic vec_t hz(input logic [8:0] x1,
                              input logic [8:0] x3);
    return mk(1, 5, 5, 0, 1, 0, 0, 0, 0, x1, x3);
  endfunction

  function automatic vec_t nop(input logic [8:0] x1,
                               input logic [8:0] x3);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, x1, x3);
  endfunction

  task automatic drv(input vec_t v);
    b1.i_idex_rdwren = v.ld;   b3.i_idex_rdwren = v.ld;
    b1.i_idex_mem_rden = v.ld; b3.i_idex_mem_rden = v.ld;
    b1.i_idex_rd = v.rd;       b3.i_idex_rd = v.rd;
    b1.i_ifid_rs1 = v.rs1;     b3.i_ifid_rs1 = v.rs1;
    b1.i_ifid_rs2 = v.rs2;     b3.i_ifid_rs2 = v.rs2;
    b1.i_ifid_rs1_en = v.e1n;  b3.i_ifid_rs1_en = v.e1n;
    b1.i_ifid_rs2_en = v.e2n;  b3.i_ifid_rs2_en = v.e2n;
    b1.i_br_flush = v.br;      b3.i_br_flush = v.br;
    b1.i_sram_stall = v.sr;    b3.i_sram_stall = v.sr;
    b1.i_ex_busy = v.bz;       b3.i_ex_busy = v.bz;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    drv(nop(NORM, NORM));
    #3;
    chk("rst_u1", 32'(o1), 32'(RST));
    chk("rst_u3", 32'(o3), 32'(RST));
    chk("rst_cnt", 32'(b3.o_sram_stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // plain hazard: 1 vs 3 bubbles
    tv.push_back(nop(NORM, NORM));
    tv.push_back(hz(BUB0, BUB0));
    tv.push_back(nop(NORM, BUB1));
    tv.push_back(nop(NORM, BUB1));
    tv.push_back(nop(NORM, NORM));
    // rd=0 and disabled rs2 never stall
    tv.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, NORM, NORM));
    tv.push_back(mk(1, 7, 3, 7, 1, 0, 0, 0, 0, NORM, NORM));
    tv.push_back(mk(1, 7, 3, 7, 1, 1, 0, 0, 0, BUB0, BUB0));
    tv.push_back(nop(NORM, BUB1));
    tv.push_back(nop(NORM, BUB1));
    // sram stall freezes the bubble count
    tv.push_back(hz(BUB0, BUB0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, STAL, STAL1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, STAL, STAL1));
    tv.push_back(nop(NORM, BUB1));
    tv.push_back(nop(NORM, BUB1));
    tv.push_back(nop(NORM, NORM));
    // flush latched under stall, applied once
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, STAL, STAL));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, STAL, STAL));
    tv.push_back(nop(FLSH, FLSH));
    tv.push_back(nop(NORM, NORM));
    // ex busy masks hazard, then bubbles, then flush aborts
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(1, 5, 5, 0, 1, 0, 0, 0, 1, BUSY, BUSY));
    tv.push_back(hz(BUB0, BUB0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, FLSH, FLSH1));
    tv.push_back(nop(NORM, NORM));
    // flush outranks busy
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, FLSH, FLSH));
    tv.push_back(nop(NORM, NORM));
    // stall outranks hazard; busy inside LU_STALL holds count
    tv.push_back(mk(1, 5, 5, 0, 1, 0, 0, 1, 0, STAL, STAL));
    tv.push_back(hz(BUB0, BUB0));
    tv.push_back(nop(NORM, BUB1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, BUSY, BUSY1));
    tv.push_back(nop(NORM, BUB1));
    tv.push_back(nop(NORM, NORM));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drv(tv[i]);
      #2;
      chk($sformatf("v%0d_u1", i), 32'(o1), 32'(tv[i].x1));
      chk($sformatf("v%0d_u3", i), 32'(o3), 32'(tv[i].x3));
    end

    @(negedge clk);
`ifdef HDU_PERF_CNT_EN
    chk("u3_sram_cnt", 32'(b3.o_sram_stall_cnt), 5);
    chk("u3_lu_cnt", 32'(b3.o_lu_bubble_cnt), 13);
    chk("u3_fl_cnt", 32'(b3.o_flush_cnt), 3);
    chk("u3_busy_cnt", 32'(b3.o_busy_cnt), 5);
    chk("u1_lu_cnt", b1.o_lu_bubble_cnt, 5);
`else
    chk("u3_sram_cnt", 32'(b3.o_sram_stall_cnt), 0);
    chk("u3_lu_cnt", 32'(b3.o_lu_bubble_cnt), 0);
    chk("u3_fl_cnt", 32'(b3.o_flush_cnt), 0);
    chk("u3_busy_cnt", 32'(b3.o_busy_cnt), 0);
    chk("u1_lu_cnt", b1.o_lu_bubble_cnt, 0);
`endif

    drv(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, STAL, STAL));
    repeat (20) @(negedge clk);
`ifdef HDU_PERF_CNT_EN
    chk("u3_sram_sat", 32'(b3.o_sram_stall_cnt), 15);
    chk("u1_sram_cnt", b1.o_sram_stall_cnt, 25);
`else
    chk("u3_sram_sat", 32'(b3.o_sram_stall_cnt), 0);
    chk("u1_sram_cnt", b1.o_sram_stall_cnt, 0);
`endif

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_u1", 32'(o1), 32'(RST));
    chk("arst_u3", 32'(o3), 32'(RST));
    chk("arst_sram", 32'(b3.o_sram_stall_cnt), 0);
    chk("arst_lu", 32'(b3.o_lu_bubble_cnt), 0);
    chk("arst_fl", 32'(b3.o_flush_cnt), 0);
    chk("arst_busy", 32'(b3.o_busy_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
